reservation_station: RTL and testbench

RESERVATION_STATION -- requirements
Module: reservation_station

---
 rtl/reservation_station.sv | 196 +++++++++++++++++++
 tb/tb_reservation_station.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - three-entry reservation station with CDB snoop and single-FU dispatch FSM
module reservation_station #(
    parameter logic [2:0] TAG_BASE = 3'd1
) (
    input  logic        CLK,
    input  logic        CLR,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [15:0] issue_vj,
    input  logic [15:0] issue_vk,
    input  logic [2:0]  issue_qj,
    input  logic [2:0]  issue_qk,
    output logic        issue_ready,
    output logic [2:0]  issue_tag,
    input  logic        cdb_valid,
    input  logic [2:0]  cdb_tag,
    input  logic [15:0] cdb_data,
    output logic        fu_start,
    output logic [2:0]  fu_id,
    output logic [15:0] fu_a,
    output logic [15:0] fu_b,
    output logic [2:0]  fu_op,
    input  logic [18:0] fu_result,
    input  logic        fu_done,
    input  logic        fu_busy,
    output logic        res_valid,
    output logic [2:0]  res_tag,
    output logic [15:0] res_data
);
    typedef enum logic [1:0] {IDLE, START, WAIT, BCAST} state_t;

    state_t      state_q, state_d;
    logic [2:0]  busy_q, busy_d, disp_q, disp_d;
    logic [2:0]  op_q [0:2];
    logic [2:0]  op_d [0:2];
    logic [2:0]  qj_q [0:2];
    logic [2:0]  qj_d [0:2];
    logic [2:0]  qk_q [0:2];
    logic [2:0]  qk_d [0:2];
    logic [15:0] vj_q [0:2];
    logic [15:0] vj_d [0:2];
    logic [15:0] vk_q [0:2];
    logic [15:0] vk_d [0:2];
    logic [1:0]  sel_q, sel_d;
    logic [2:0]  fu_id_q, fu_id_d, fu_op_q, fu_op_d;
    logic [15:0] fu_a_q, fu_a_d, fu_b_q, fu_b_d, result_q, result_d;

    logic [1:0]  free_idx, rdy_idx;
    logic        any_free, any_rdy, cdb_hit;
    logic        unused_result_hi;

    assign unused_result_hi = ^fu_result[18:16];
    assign cdb_hit = cdb_valid && (cdb_tag != 3'd0);

    // Descending scans so the lowest qualifying index wins.
    always_comb begin
        free_idx = 2'd0;
        any_free = 1'b0;
        rdy_idx  = 2'd0;
        any_rdy  = 1'b0;
        for (int i = 2; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_idx = 2'(i);
                any_free = 1'b1;
            end
            if (busy_q[i] && !disp_q[i] && qj_q[i] == 3'd0 && qk_q[i] == 3'd0) begin
                rdy_idx = 2'(i);
                any_rdy = 1'b1;
            end
        end
    end

    assign issue_ready = any_free;
    assign issue_tag   = TAG_BASE + 3'(free_idx);
    assign fu_start    = (state_q == START);
    assign res_valid   = (state_q == BCAST);
    assign res_tag     = res_valid ? fu_id_q : 3'd0;
    assign res_data    = res_valid ? result_q : 16'd0;
    assign fu_id       = fu_id_q;
    assign fu_a        = fu_a_q;
    assign fu_b        = fu_b_q;
    assign fu_op       = fu_op_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        disp_d   = disp_q;
        sel_d    = sel_q;
        fu_id_d  = fu_id_q;
        fu_op_d  = fu_op_q;
        fu_a_d   = fu_a_q;
        fu_b_d   = fu_b_q;
        result_d = result_q;
        for (int i = 0; i < 3; i++) begin
            op_d[i] = op_q[i];
            qj_d[i] = qj_q[i];
            qk_d[i] = qk_q[i];
            vj_d[i] = vj_q[i];
            vk_d[i] = vk_q[i];
            if (busy_q[i] && cdb_hit && qj_q[i] == cdb_tag) begin
                vj_d[i] = cdb_data;
                qj_d[i] = 3'd0;
            end
            if (busy_q[i] && cdb_hit && qk_q[i] == cdb_tag) begin
                vk_d[i] = cdb_data;
                qk_d[i] = 3'd0;
            end
        end

        // A tag broadcast in the issue cycle would be missed by the snoop, so capture it here.
        if (issue_valid && any_free) begin
            busy_d[free_idx] = 1'b1;
            disp_d[free_idx] = 1'b0;
            op_d[free_idx]   = issue_op;
            if (cdb_hit && issue_qj == cdb_tag) begin
                vj_d[free_idx] = cdb_data;
                qj_d[free_idx] = 3'd0;
            end else begin
                vj_d[free_idx] = issue_vj;
                qj_d[free_idx] = issue_qj;
            end
            if (cdb_hit && issue_qk == cdb_tag) begin
                vk_d[free_idx] = cdb_data;
                qk_d[free_idx] = 3'd0;
            end else begin
                vk_d[free_idx] = issue_vk;
                qk_d[free_idx] = issue_qk;
            end
        end

        case (state_q)
            IDLE: begin
                if (any_rdy && !fu_busy) begin
                    sel_d           = rdy_idx;
                    fu_id_d         = TAG_BASE + 3'(rdy_idx);
                    fu_op_d         = op_q[rdy_idx];
                    fu_a_d          = vj_q[rdy_idx];
                    fu_b_d          = vk_q[rdy_idx];
                    disp_d[rdy_idx] = 1'b1;
                    state_d         = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (fu_done && !fu_busy) begin
                    result_d = fu_result[15:0];
                    state_d  = BCAST;
                end
            end
            BCAST: begin
                busy_d[sel_q] = 1'b0;
                disp_d[sel_q] = 1'b0;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            busy_q   <= 3'd0;
            disp_q   <= 3'd0;
            sel_q    <= 2'd0;
            fu_id_q  <= 3'd0;
            fu_op_q  <= 3'd0;
            fu_a_q   <= 16'd0;
            fu_b_q   <= 16'd0;
            result_q <= 16'd0;
            for (int i = 0; i < 3; i++) begin
                op_q[i] <= 3'd0;
                qj_q[i] <= 3'd0;
                qk_q[i] <= 3'd0;
                vj_q[i] <= 16'd0;
                vk_q[i] <= 16'd0;
            end
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            disp_q   <= disp_d;
            sel_q    <= sel_d;
            fu_id_q  <= fu_id_d;
            fu_op_q  <= fu_op_d;
            fu_a_q   <= fu_a_d;
            fu_b_q   <= fu_b_d;
            result_q <= result_d;
            for (int i = 0; i < 3; i++) begin
                op_q[i] <= op_d[i];
                qj_q[i] <= qj_d[i];
                qk_q[i] <= qk_d[i];
                vj_q[i] <= vj_d[i];
                vk_q[i] <= vk_d[i];
            end
        end
    end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - directed bench for reservation_station with a fixed-latency FU model
module tb_reservation_station;
    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic        issue_valid = 1'b0;
    logic [2:0]  issue_op = 3'd0;
    logic [15:0] issue_vj = 16'd0, issue_vk = 16'd0;
    logic [2:0]  issue_qj = 3'd0, issue_qk = 3'd0;
    logic        issue_ready;
    logic [2:0]  issue_tag;
    logic        cdb_valid = 1'b0;
    logic [2:0]  cdb_tag = 3'd0;
    logic [15:0] cdb_data = 16'd0;
    logic        fu_start;
    logic [2:0]  fu_id, fu_op;
    logic [15:0] fu_a, fu_b;
    logic [18:0] fu_result = 19'd0;
    logic        fu_done = 1'b0;
    logic        fu_busy;
    logic        res_valid;
    logic [2:0]  res_tag;
    logic [15:0] res_data;

    logic        fu_busy_int = 1'b0;
    logic        hold_busy = 1'b0;
    int          cnt = 0;
    logic [15:0] cap_a, cap_b;
    int          n_vec = 0;
    int          n_bad = 0;
    int          st_id[$];
    int          st_a[$];
    int          st_b[$];
    int          st_op[$];
    int          r_tag[$];
    int          r_data[$];

    assign fu_busy = fu_busy_int | hold_busy;

    reservation_station #(.TAG_BASE(3'd1)) dut (
        .CLK(CLK), .CLR(CLR),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_vk(issue_vk),
        .issue_qj(issue_qj), .issue_qk(issue_qk),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .fu_start(fu_start), .fu_id(fu_id), .fu_a(fu_a), .fu_b(fu_b), .fu_op(fu_op),
        .fu_result(fu_result), .fu_done(fu_done), .fu_busy(fu_busy),
        .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FU model: done three cycles after the start pulse; upper result bits carry junk.
    always @(negedge CLK) begin
        if (CLR) begin
            cnt = 0;
            fu_done = 1'b0;
            fu_busy_int = 1'b0;
        end else begin
            fu_done = 1'b0;
            if (fu_start) begin
                st_id.push_back(int'(fu_id));
                st_a.push_back(int'(fu_a));
                st_b.push_back(int'(fu_b));
                st_op.push_back(int'(fu_op));
                cap_a = fu_a;
                cap_b = fu_b;
                case (fu_op)
                    3'b001:  fu_result = {3'b101, fu_a + fu_b};
                    3'b010:  fu_result = {3'b110, fu_a - fu_b};
                    default: fu_result = {3'b111, fu_a ^ fu_b};
                endcase
                fu_busy_int = 1'b1;
                cnt = 3;
            end else if (cnt != 0) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    check("hold_a", fu_a, cap_a);
                    check("hold_b", fu_b, cap_b);
                    fu_done = 1'b1;
                    fu_busy_int = 1'b0;
                end
            end
            if (res_valid) begin
                r_tag.push_back(int'(res_tag));
                r_data.push_back(int'(res_data));
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic clear_logs();
        st_id.delete(); st_a.delete(); st_b.delete(); st_op.delete();
        r_tag.delete(); r_data.delete();
    endtask

    task automatic do_issue(input logic [2:0] op, input logic [15:0] vj, input logic [15:0] vk,
                            input logic [2:0] qj, input logic [2:0] qk);
        issue_valid = 1'b1;
        issue_op = op; issue_vj = vj; issue_vk = vk; issue_qj = qj; issue_qk = qk;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic cdb_pulse(input logic [2:0] tag, input logic [15:0] data);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_data = data;
        tick();
        cdb_valid = 1'b0;
    endtask

    task automatic wait_res(input int n);
        int k = 0;
        while (r_tag.size() < n && k < 80) begin
            tick();
            k++;
        end
        check("res_count_wait", r_tag.size(), n);
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_fu_start"}, fu_start, 0);
        check({pfx, "_res_valid"}, res_valid, 0);
        check({pfx, "_fu_id"}, fu_id, 0);
        check({pfx, "_fu_a"}, fu_a, 0);
        check({pfx, "_fu_b"}, fu_b, 0);
        check({pfx, "_fu_op"}, fu_op, 0);
        check({pfx, "_res_tag"}, res_tag, 0);
        check({pfx, "_res_data"}, res_data, 0);
        check({pfx, "_issue_ready"}, issue_ready, 1);
        check({pfx, "_issue_tag"}, issue_tag, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) tick();
        check_reset_outputs("rst");
        CLR = 1'b0;
        tick();

        // Simple add, operands present
        clear_logs();
        do_issue(3'b001, 16'd5, 16'd7, 3'd0, 3'd0);
        wait_res(1);
        check("t1_starts", st_id.size(), 1);
        if (st_id.size() == 1) begin
            check("t1_fu_id", st_id[0], 1);
            check("t1_fu_a", st_a[0], 5);
            check("t1_fu_b", st_b[0], 7);
            check("t1_fu_op", st_op[0], 1);
        end
        if (r_tag.size() >= 1) begin
            check("t1_res_tag", r_tag[0], 1);
            check("t1_res_data", r_data[0], 12);
        end
        tick();
        check("t1_ready_after", issue_ready, 1);
        check("t1_tag_after", issue_tag, 1);
        repeat (3) tick();
        check("t1_one_bcast", r_tag.size(), 1);

        // Waiting operand resolved by the CDB
        clear_logs();
        do_issue(3'b010, 16'd0, 16'd3, 3'd2, 3'd0);
        repeat (6) tick();
        check("t2_no_early_start", st_id.size(), 0);
        cdb_pulse(3'd2, 16'd10);
        wait_res(1);
        if (r_tag.size() >= 1) begin
            check("t2_res_data", r_data[0], 7);
            check("t2_res_tag", r_tag[0], 1);
        end
        if (st_a.size() >= 1) check("t2_fu_a", st_a[0], 10);
        repeat (3) tick();

        // Fill all entries while FU is busy; fourth issue must be dropped
        clear_logs();
        hold_busy = 1'b1;
        do_issue(3'b001, 16'd1, 16'd1, 3'd0, 3'd0);
        check("t3_tag_second", issue_tag, 2);
        do_issue(3'b001, 16'd2, 16'd2, 3'd0, 3'd0);
        check("t3_tag_third", issue_tag, 3);
        do_issue(3'b001, 16'd3, 16'd3, 3'd0, 3'd0);
        check("t3_full", issue_ready, 0);
        do_issue(3'b001, 16'd100, 16'd100, 3'd0, 3'd0);
        check("t3_still_full", issue_ready, 0);
        check("t3_no_start_busy", st_id.size(), 0);
        hold_busy = 1'b0;
        wait_res(3);
        if (r_tag.size() >= 3) begin
            check("t3_tag0", r_tag[0], 1);
            check("t3_tag1", r_tag[1], 2);
            check("t3_tag2", r_tag[2], 3);
            check("t3_data0", r_data[0], 2);
            check("t3_data1", r_data[1], 4);
            check("t3_data2", r_data[2], 6);
        end
        repeat (12) tick();
        check("t3_no_fourth", r_tag.size(), 3);
        check("t3_ready_end", issue_ready, 1);

        // Same-cycle CDB bypass on qk
        clear_logs();
        cdb_valid = 1'b1; cdb_tag = 3'd4; cdb_data = 16'd9;
        do_issue(3'b001, 16'd1, 16'd0, 3'd0, 3'd4);
        cdb_valid = 1'b0;
        wait_res(1);
        if (r_tag.size() >= 1) begin
            check("t4_res_data", r_data[0], 10);
            check("t4_res_tag", r_tag[0], 1);
        end
        repeat (3) tick();

        // Tag-0 and unmatched CDB cycles have no effect
        clear_logs();
        do_issue(3'b001, 16'd0, 16'd1, 3'd5, 3'd0);
        cdb_pulse(3'd0, 16'd50);
        cdb_pulse(3'd6, 16'd50);
        repeat (4) tick();
        check("t5_no_start", st_id.size(), 0);
        cdb_pulse(3'd5, 16'd20);
        wait_res(1);
        if (r_tag.size() >= 1) check("t5_res_data", r_data[0], 21);
        repeat (3) tick();

        // Reset during WAIT aborts the operation
        clear_logs();
        do_issue(3'b001, 16'd1, 16'd1, 3'd0, 3'd0);
        for (int k = 0; k < 20 && st_id.size() == 0; k++) tick();
        check("t6_started", st_id.size(), 1);
        tick();
        CLR = 1'b1;
        #1;
        check_reset_outputs("t6");
        tick();
        CLR = 1'b0;
        repeat (10) tick();
        check("t6_no_bcast", r_tag.size(), 0);
        check("t6_no_restart", st_id.size(), 1);
        check("t6_ready", issue_ready, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
